// File: rtl/binary_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : binary_frame_packer
// Purpose  : Tail sink of the binary (1-bit) video pipeline. Collects the
//            pixels of each frame, packs them LSB-first into DATA_WIDTH-bit
//            words and writes them to a frame-buffer RAM port at raster word
//            addresses. Checks frame geometry and reports per-frame errors.
// Ports    : clk              pixel clock
//            rst              synchronous, active-high reset
//            per_frame_vsync  high for the whole frame
//            per_frame_href   high during an active line
//            per_frame_clken  pixel valid qualifier
//            per_img_Bit      binary pixel
//            wr_en            one-cycle RAM write strobe
//            wr_addr          word address
//            wr_data          packed pixels, bit 0 = leftmost pixel
//            frame_done       one-cycle pulse at frame end
//            err_flags        [0] short line, [1] long line,
//                             [2] line-count mismatch (held between frames)
// Revision : 1.0 - initial release
// ============================================================================
module binary_frame_packer #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic                  per_img_Bit,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_done,
    output logic [2:0]            err_flags
);

    localparam int c_PIX_W  = $clog2(IMG_HDISP + 1);
    localparam int c_LINE_W = $clog2(IMG_VDISP + 1);
    localparam int c_IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_PIX_W-1:0]    c_HDISP    = c_PIX_W'(IMG_HDISP);
    localparam logic [c_LINE_W-1:0]   c_VDISP    = c_LINE_W'(IMG_VDISP);
    localparam logic [ADDR_WIDTH-1:0] c_WORDS    = ADDR_WIDTH'(IMG_HDISP / DATA_WIDTH);
    localparam logic [c_IDX_W-1:0]    c_LAST_BIT = c_IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  vsync_q, href_q;
    logic [c_PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [c_LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [c_IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  acc_short_q, acc_short_d;
    logic                  acc_long_q, acc_long_d;
    logic                  acc_lines_q, acc_lines_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_done_q, frame_done_d;
    logic [2:0]            err_flags_q, err_flags_d;

    logic w_vs_rise, w_vs_fall, w_href_fall, w_pix_valid;

    always_comb begin
        w_vs_rise   = per_frame_vsync & ~vsync_q;
        w_vs_fall   = ~per_frame_vsync & vsync_q;
        w_href_fall = href_q & ~per_frame_href;
        w_pix_valid = per_frame_vsync & per_frame_href & per_frame_clken;

        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        line_base_d  = line_base_q;
        word_idx_d   = word_idx_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        acc_short_d  = acc_short_q;
        acc_long_d   = acc_long_q;
        acc_lines_d  = acc_lines_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        err_flags_d  = err_flags_q;

        case (state_q)
            // Wait for a gap between frames so a frame already in progress
            // at reset release is never partially captured.
            S_IDLE: begin
                if (!vsync_q) begin
                    state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                if (w_vs_rise) begin
                    pix_cnt_d   = '0;
                    line_cnt_d  = '0;
                    line_base_d = '0;
                    word_idx_d  = '0;
                    bit_idx_d   = '0;
                    acc_short_d = 1'b0;
                    acc_long_d  = 1'b0;
                    acc_lines_d = 1'b0;
                    state_d     = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (w_pix_valid) begin
                    if ((pix_cnt_q < c_HDISP) && (line_cnt_q < c_VDISP)) begin
                        // A new word starts clean so a flushed partial word
                        // is zero-padded above its last pixel.
                        shift_d            = (bit_idx_q == '0) ? '0 : shift_q;
                        shift_d[bit_idx_q] = per_img_Bit;
                        pix_cnt_d          = pix_cnt_q + c_PIX_W'(1);
                        if (bit_idx_q == c_LAST_BIT) begin
                            wr_en_d    = 1'b1;
                            wr_data_d  = shift_d;
                            wr_addr_d  = line_base_q + word_idx_q;
                            bit_idx_d  = '0;
                            word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                        end else begin
                            bit_idx_d  = bit_idx_q + c_IDX_W'(1);
                        end
                    end else begin
                        if (pix_cnt_q == c_HDISP) begin
                            acc_long_d = 1'b1;
                        end
                        if (line_cnt_q == c_VDISP) begin
                            acc_lines_d = 1'b1;
                        end
                    end
                end

                // Line end; a vsync fall also closes a line still open.
                if (w_href_fall || w_vs_fall) begin
                    if (pix_cnt_q != '0) begin
                        if (bit_idx_q != '0) begin
                            wr_en_d     = 1'b1;
                            wr_data_d   = shift_q;
                            wr_addr_d   = line_base_q + word_idx_q;
                            acc_short_d = 1'b1;
                        end else if (pix_cnt_q < c_HDISP) begin
                            acc_short_d = 1'b1;
                        end
                        line_cnt_d  = line_cnt_q + c_LINE_W'(1);
                        line_base_d = line_base_q + c_WORDS;
                        pix_cnt_d   = '0;
                        bit_idx_d   = '0;
                        word_idx_d  = '0;
                    end
                end

                // Frame end uses the line count after closing the last line.
                if (w_vs_fall) begin
                    if (line_cnt_d != c_VDISP) begin
                        acc_lines_d = 1'b1;
                    end
                    frame_done_d = 1'b1;
                    err_flags_d  = {acc_lines_d, acc_long_d, acc_short_d};
                    state_d      = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_ARMED;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            line_base_q  <= '0;
            word_idx_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            acc_short_q  <= 1'b0;
            acc_long_q   <= 1'b0;
            acc_lines_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            err_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= per_frame_vsync;
            href_q       <= per_frame_href;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            line_base_q  <= line_base_d;
            word_idx_q   <= word_idx_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            acc_short_q  <= acc_short_d;
            acc_long_q   <= acc_long_d;
            acc_lines_q  <= acc_lines_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            err_flags_q  <= err_flags_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign err_flags  = err_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_frame_packer
// Purpose  : Scoreboard bench for binary_frame_packer. The stimulus process
//            drives frames and queues the expected RAM writes and frame_done
//            results; a monitor pops and compares whenever the DUT responds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_binary_frame_packer;

    localparam int H  = 32;
    localparam int V  = 4;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          vs, hr, ck, bt;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_done;
    logic [2:0]    err_flags;

    binary_frame_packer #(
        .IMG_HDISP  (H),
        .IMG_VDISP  (V),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .per_frame_vsync (vs),
        .per_frame_href  (hr),
        .per_frame_clken (ck),
        .per_img_Bit     (bt),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .frame_done      (frame_done),
        .err_flags       (err_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } wr_exp_t;
    typedef struct { int err; int cyc; } done_exp_t;

    wr_exp_t   exp_wr[$];
    done_exp_t exp_done[$];

    int n_chk    = 0;
    int n_pass   = 0;
    int last_err = 0;
    bit mon_en   = 1'b0;

    // Frame description: pixel values per line and line lengths.
    bit pix[0:7][0:63];
    int len[0:7];
    int nl;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares every DUT response against the head of its queue.
    always @(negedge clk) begin
        if (mon_en && wr_en) begin
            if (exp_wr.size() == 0) begin
                check("write_without_expectation", int'(wr_en), 0);
            end else begin
                wr_exp_t e;
                e = exp_wr.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (mon_en && frame_done) begin
            if (exp_done.size() == 0) begin
                check("frame_done_without_expectation", int'(frame_done), 0);
            end else begin
                done_exp_t d;
                d = exp_done.pop_front();
                check("err_flags", int'(err_flags), d.err);
                check("frame_done_cycle", cyc, d.cyc);
            end
        end
    end

    // Packed word w of line y, counting only the first n pixels of the line.
    function automatic int word_of(input int y, input int w, input int n);
        int d;
        d = 0;
        for (int i = 0; i < DW; i++)
            if (w * DW + i < n) d = d | (int'(pix[y][w * DW + i]) << i);
        return d;
    endfunction

    task automatic push_wr(input int a, input int d, input int c);
        wr_exp_t e;
        e.addr = a; e.data = d; e.cyc = c;
        exp_wr.push_back(e);
    endtask

    task automatic drive(input bit v, input bit h, input bit c, input bit b);
        @(negedge clk);
        vs = v; hr = h; ck = c; bt = b;
    endtask

    task automatic fill_pattern(input int lines);
        nl = lines;
        for (int y = 0; y < 8; y++) begin
            len[y] = (y < lines) ? H : 0;
            for (int x = 0; x < 64; x++) pix[y][x] = bit'((x + y) & 1);
        end
    endtask

    task automatic fill_random(input int lines, input int lo, input int hi);
        nl = lines;
        for (int y = 0; y < 8; y++) begin
            len[y] = (y < lines) ? int'($urandom_range(hi, lo)) : 0;
            for (int x = 0; x < 64; x++) pix[y][x] = bit'($urandom_range(1, 0));
        end
    endtask

    // gap_mode: 0 = clken every cycle, 1 = alternating, 2 = random gaps.
    // abort_at: line index before which rst is pulsed (-1 = never).
    // joint_end: vsync and href fall together after the last pixel.
    task automatic run_frame(input int gap_mode, input int abort_at, input bit joint_end);
        int  err_short, err_long, err, gaps, n_acc;
        bit  live, last;
        err_short = 0; err_long = 0; live = 1'b1;

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("err_flags_held", int'(err_flags), last_err);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        for (int y = 0; y < nl; y++) begin
            if (y == abort_at) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                live = 1'b0;
                last_err = 0;
                check("err_flags_after_reset", int'(err_flags), 0);
                check("wr_en_after_reset", int'(wr_en), 0);
            end
            for (int p = 0; p < len[y]; p++) begin
                case (gap_mode)
                    0:       gaps = 0;
                    1:       gaps = (p > 0) ? 1 : 0;
                    default: gaps = int'($urandom_range(2, 0));
                endcase
                repeat (gaps) drive(1'b1, 1'b1, 1'b0, bit'($urandom_range(1, 0)));
                drive(1'b1, 1'b1, 1'b1, pix[y][p]);
                if (live && y < V && p < H && (p % DW) == DW - 1)
                    push_wr(y * (H / DW) + p / DW, word_of(y, p / DW, H), cyc + 1);
            end
            n_acc = (y < V) ? ((len[y] < H) ? len[y] : H) : 0;
            if (y < V && len[y] < H) err_short = 1;
            if (y < V && len[y] > H) err_long = 1;
            last = joint_end && (y == nl - 1);
            if (last) drive(1'b0, 1'b0, 1'b0, 1'b0);
            else      drive(1'b1, 1'b0, 1'b0, 1'b0);
            if (live && (n_acc % DW) != 0)
                push_wr(y * (H / DW) + n_acc / DW, word_of(y, n_acc / DW, n_acc), cyc + 1);
            if (!last) drive(1'b1, 1'b0, 1'b0, 1'b0);
        end

        if (!joint_end) drive(1'b0, 1'b0, 1'b0, 1'b0);
        err = ((nl != V) ? 4 : 0) | (err_long << 1) | err_short;
        if (live) begin
            done_exp_t d;
            d.err = err; d.cyc = cyc + 1;
            exp_done.push_back(d);
            last_err = err;
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; hr = 1'b0; ck = 1'b0; bt = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_wr_addr", int'(wr_addr), 0);
        check("reset_wr_data", int'(wr_data), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_err_flags", int'(err_flags), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Nominal frame, clken every cycle.
        fill_pattern(4);
        run_frame(0, -1, 1'b0);

        // clken toggling within lines.
        fill_pattern(4);
        run_frame(1, -1, 1'b0);

        // Short line 2 of 20 ones.
        fill_pattern(4);
        len[2] = 20;
        for (int x = 0; x < 20; x++) pix[2][x] = 1'b1;
        run_frame(2, -1, 1'b0);

        // Long line 1 and an extra fifth line.
        fill_random(5, H, H);
        len[1] = 35;
        run_frame(2, -1, 1'b0);

        // Reset mid-frame, then a clean nominal frame.
        fill_pattern(4);
        run_frame(2, 2, 1'b0);
        fill_pattern(4);
        run_frame(0, -1, 1'b0);

        // vsync and href fall together at the end of the last line.
        fill_pattern(4);
        run_frame(2, -1, 1'b1);

        // Random geometries and contents.
        for (int f = 0; f < 4; f++) begin
            fill_random(int'($urandom_range(5, 3)), 1, 40);
            run_frame(2, -1, bit'($urandom_range(1, 0)));
        end

        repeat (10) @(negedge clk);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_frame_done", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
